mic_sample_arbiter: RTL
=======================

MIC_SAMPLE_ARBITER -- requirements
Module: mic_sample_arbiter

Interface
- REQ-001 SHALL have parameter NUM_CH, default 4, number of CIC microphone channels (2..8).
- REQ-002 SHALL have parameter DW, default 32, CIC sample width.
- REQ-003 SHALL have port clk  input  1  system clock (50 MHz).
- REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
- REQ-005 SHALL have port enable  input  1  capture enable.
- REQ-006 SHALL have port ch_data  input  NUM_CH*DW  per-channel CIC output; channel i at bits [i*DW +: DW].
- REQ-007 SHALL have port ch_valid  input  NUM_CH  per-channel one-cycle sample strobes.
- REQ-008 SHALL have port out_data  output  DW  granted sample.
- REQ-009 SHALL have port out_ch  output  3  channel index of out_data.
- REQ-010 SHALL have port out_valid  output  1  output sample valid.
- REQ-011 SHALL have port out_ready  input  1  downstream accept.
- REQ-012 SHALL have port overrun  output  NUM_CH  sticky per-channel drop flags.
- REQ-013 SHALL have port clr_overrun  input  1  clears all overrun flags.
- REQ-014 SHALL have port busy  output  1  high in states RUN and DRAIN.

Function
- REQ-015 SHALL implement FSM IDLE -> RUN on enable=1; RUN -> DRAIN on enable=0; DRAIN -> IDLE once all hold registers and the output register are empty; DRAIN -> RUN on enable=1.
- REQ-016 SHALL hold one DW-bit sample per channel; in RUN, ch_valid[i]=1 at edge k SHALL mark hold i full after edge k.
- REQ-017 SHALL NOT capture in IDLE or DRAIN; held samples SHALL still drain in DRAIN.
- REQ-018 SHALL, when hold i is full, not being granted that cycle, and ch_valid[i]=1, drop the new sample, keep the old one, and set overrun[i].
- REQ-019 SHALL, when hold i is granted and ch_valid[i]=1 in the same cycle, capture the new sample with no overrun.
- REQ-020 SHALL grant round-robin among full holds, searching from (last grant + 1) mod NUM_CH, when the output register is empty or out_valid&&out_ready.
- REQ-021 SHALL load out_data/out_ch and clear the granted hold on the same edge; minimum latency: ch_valid at edge k -> out_valid high after edge k+1.
- REQ-022 SHALL keep out_data/out_ch/out_valid stable while out_valid=1 and out_ready=0.
- REQ-023 SHALL sustain one sample per cycle with out_ready held high.
- REQ-024 SHALL clear overrun on clr_overrun=1; a coincident new overrun event SHALL win (flag set).

Reset
- REQ-025 SHALL on rst: state IDLE, all holds empty, out_valid=0, out_data=0, out_ch=0, overrun=0, busy=0, last grant = NUM_CH-1 (so channel 0 wins first).
- REQ-026 SHALL let rst mid-transfer discard all held and pending samples without asserting out_valid in the reset cycle.

Configuration
- REQ-027 SHALL, with MIC_SAMPLE_ARBITER_TIMESTAMP_EN defined, add output out_ts (16 bits): value of a free-running cycle counter (reset 0, wraps 65535->0) latched into hold i at capture and forwarded with its sample.
- REQ-028 SHALL, without MIC_SAMPLE_ARBITER_TIMESTAMP_EN, have no out_ts port and no counter logic.

Structure
- REQ-029 SHALL place MIC_MAX_CH=8, MIC_DW=32, the FSM state typedef (IDLE/RUN/DRAIN) and the timestamp width constant in package mic_pkg.
- REQ-030 SHALL put the round-robin grant (request vector, last grant -> one-hot grant plus index) in sub-module mic_rr_arbiter.

Verification
- REQ-031 Single sample: enable=1, ch_valid[2]=1 with 0x0000_1234, out_ready=1 -> out_valid one cycle later, out_data=0x0000_1234, out_ch=2.
- REQ-032 Fairness: ch_valid=4'b1111 same cycle, data 0xA0..0xA3, out_ready=1 -> outputs ch 0,1,2,3 on consecutive cycles; repeat -> order 0,1,2,3 again.
- REQ-033 Backpressure/overrun: out_ready=0, ch_valid[1] twice (0x11 then 0x22), plus ch_valid[0] (0x05) -> out_data=0x05 held stable, overrun=4'b0010; release out_ready -> 0x05 then 0x11; 0x22 never appears; clr_overrun -> overrun=0.
- REQ-034 Drain: hold 2 samples, drop enable -> busy=1 until both delivered, then IDLE, busy=0; ch_valid in DRAIN ignored, no overrun.
- REQ-035 Reset mid-operation: rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, overrun=0; first post-reset grant is channel 0.
- REQ-036 Timestamp (macro defined): captures at counter values 100 and 65535 -> out_ts=100 and 65535; next capture after wrap carries a small value.

Source files
------------

// File: rtl/mic_pkg.sv
// mic_pkg: shared constants and FSM type for the microphone sample arbiter
// Contents: channel/width limits, timestamp width, grant-index width, FSM states.
package mic_pkg;
   localparam int MIC_MAX_CH = 8;
   localparam int MIC_DW     = 32;
   localparam int MIC_TS_W   = 16;
   localparam int MIC_IDX_W  = $clog2(MIC_MAX_CH);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} mic_state_e;
endpackage

// File: rtl/mic_rr_arbiter.sv
// mic_rr_arbiter: round-robin grant among requesting channels
// Ports: req_i request vector, last_i previous grant index,
//        gnt_o one-hot grant, idx_o grant index, any_o some request granted.
module mic_rr_arbiter
   import mic_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [MIC_IDX_W-1:0] last_i,
   output logic [N-1:0]         gnt_o,
   output logic [MIC_IDX_W-1:0] idx_o,
   output logic                 any_o
);
   int best;
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      gnt_o = '0;
      best  = N;
      // distance 0 is the channel right after last_i; the nearest requester wins
      for (int i = 0; i < N; i++) begin
         if (req_i[i] && ((i + N - 1 - int'(last_i)) % N) < best) begin
            best  = (i + N - 1 - int'(last_i)) % N;
            idx_o = MIC_IDX_W'(i);
            any_o = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) gnt_o[i] = any_o && (idx_o == MIC_IDX_W'(i));
   end
endmodule

// File: rtl/mic_sample_arbiter.sv
// mic_sample_arbiter: merges per-channel CIC sample strobes into one output stream
// Ports: clk/rst (sync, active-high), enable capture enable,
//        ch_data/ch_valid per-channel samples and strobes,
//        out_data/out_ch/out_valid/out_ready output handshake,
//        overrun sticky drop flags with clr_overrun, busy in RUN or DRAIN.
// Option: MIC_SAMPLE_ARBITER_TIMESTAMP_EN adds out_ts, the capture cycle count.
module mic_sample_arbiter
   import mic_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DW     = MIC_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [NUM_CH*DW-1:0] ch_data,
   input  logic [NUM_CH-1:0]    ch_valid,
   output logic [DW-1:0]        out_data,
   output logic [MIC_IDX_W-1:0] out_ch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NUM_CH-1:0]    overrun,
   input  logic                 clr_overrun,
   output logic                 busy
`ifdef MIC_SAMPLE_ARBITER_TIMESTAMP_EN
   ,
   output logic [MIC_TS_W-1:0]  out_ts
`endif
);
   mic_state_e state_q, state_d;
   logic [NUM_CH-1:0] full_q, full_d, ovr_q, ovr_d, cap, load, gnt;
   logic [DW-1:0] hold_q [NUM_CH];
   logic [MIC_IDX_W-1:0] last_q, last_d, out_ch_q, out_ch_d, idx;
   logic [DW-1:0] out_data_q, out_data_d;
   logic out_valid_q, out_valid_d, can_load, any, empty;

   // requests are gated so no grant is issued while the output is stalled
   mic_rr_arbiter #(.N(NUM_CH)) u_rr (
      .req_i (can_load ? full_q : '0),
      .last_i(last_q),
      .gnt_o (gnt),
      .idx_o (idx),
      .any_o (any)
   );

   always_comb begin
      can_load    = !out_valid_q || out_ready;
      cap         = (state_q == RUN) ? ch_valid : '0;
      // a hold accepts a new sample when empty or emptied by this cycle's grant
      load        = cap & (~full_q | gnt);
      full_d      = (full_q & ~gnt) | cap;
      ovr_d       = (clr_overrun ? '0 : ovr_q) | (cap & full_q & ~gnt);
      out_valid_d = can_load ? any : out_valid_q;
      out_ch_d    = any ? idx : out_ch_q;
      last_d      = any ? idx : last_q;
      out_data_d  = out_data_q;
      for (int i = 0; i < NUM_CH; i++) if (gnt[i]) out_data_d = hold_q[i];
      empty       = (full_q == '0) && !out_valid_q;
      state_d     = (state_q == IDLE) ? (enable ? RUN : IDLE) :
                    enable ? RUN :
                    (state_q == RUN || !empty) ? DRAIN : IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         full_q      <= '0;
         ovr_q       <= '0;
         last_q      <= MIC_IDX_W'(NUM_CH - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         full_q      <= full_d;
         ovr_q       <= ovr_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   end

   // sample storage needs no reset: full_q alone says whether it is live
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) if (load[i]) hold_q[i] <= ch_data[i*DW +: DW];
   end

`ifdef MIC_SAMPLE_ARBITER_TIMESTAMP_EN
   logic [MIC_TS_W-1:0] ts_cnt_q, out_ts_q;
   logic [MIC_TS_W-1:0] ts_q [NUM_CH];
   logic [MIC_TS_W-1:0] out_ts_d;
   always_comb begin
      out_ts_d = out_ts_q;
      for (int i = 0; i < NUM_CH; i++) if (gnt[i]) out_ts_d = ts_q[i];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt_q <= '0;
         out_ts_q <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 1'b1;
         out_ts_q <= out_ts_d;
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) if (load[i]) ts_q[i] <= ts_cnt_q;
   end
   assign out_ts = out_ts_q;
`endif

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != IDLE);
endmodule
